// File: rtl/icache_nway_wide.sv
// icache_nway_wide
//   N-way set-associative instruction cache between the core fetch port and a
//   wide instruction memory. A hit answers one cycle after acceptance. A miss
//   fetches the whole line in one beat and forwards the critical word. The
//   replacement policy is round-robin (REPL_POLICY=0) or true LRU via per-way
//   age counters (REPL_POLICY=1). A flush invalidates one set per cycle.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   proc_valid/addr      fetch request, held until proc_ready
//   proc_ready/rdata     one-cycle response strobe and instruction word
//   flush / flush_busy   invalidate-all request / invalidation in progress
//   mem_req_valid/addr   line read request (line-aligned address)
//   mem_req_ready/rdata  one-cycle refill strobe with the full line
//   hit_count/miss_count accepted hits / misses, wrapping
module icache_nway_wide #(
  parameter int CACHE_SIZE  = 1024,
  parameter int NUM_WAYS    = 2,
  parameter int NUM_BLOCKS  = 4,
  parameter int REPL_POLICY = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      proc_valid,
  output logic                      proc_ready,
  input  logic [31:0]               proc_addr,
  output logic [31:0]               proc_rdata,
  input  logic                      flush,
  output logic                      flush_busy,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [31:0]               mem_req_addr,
  input  logic [32*NUM_BLOCKS-1:0]  mem_req_rdata,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int NUM_SETS    = CACHE_SIZE / (4 * NUM_BLOCKS * NUM_WAYS);
  localparam int OFFSET_BITS = $clog2(NUM_BLOCKS);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = 30 - OFFSET_BITS - INDEX_BITS;
  localparam int WAY_BITS    = $clog2(NUM_WAYS);
  localparam int LINE_W      = 32 * NUM_BLOCKS;
  localparam logic [WAY_BITS-1:0]   LAST_WAY = WAY_BITS'(NUM_WAYS - 1);
  localparam logic [WAY_BITS-1:0]   ONE_WAY  = WAY_BITS'(1);
  localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(NUM_SETS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_RESP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Cache storage; tags and data need no reset because valid bits gate them.
  logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0]               tag_q  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0]                 data_q [NUM_WAYS][NUM_SETS];
  logic [WAY_BITS-1:0]               rr_q   [NUM_SETS];
  logic [WAY_BITS-1:0]               age_q  [NUM_WAYS][NUM_SETS];

  logic                   proc_ready_q, proc_ready_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic                   flush_busy_q, flush_busy_d;
  logic [31:0]            mem_req_addr_q, mem_req_addr_d;
  logic [31:0]            proc_rdata_q, proc_rdata_d;
  logic [OFFSET_BITS-1:0] miss_off_q, miss_off_d;
  logic [WAY_BITS-1:0]    victim_q, victim_d;
  logic [INDEX_BITS-1:0]  flush_idx_q, flush_idx_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [31:0]            hit_count_q, hit_count_d;
  logic [31:0]            miss_count_q, miss_count_d;

  logic [OFFSET_BITS-1:0] req_off_s;
  logic [INDEX_BITS-1:0]  req_idx_s, miss_idx_s, touch_idx_s;
  logic [TAG_BITS-1:0]    req_tag_s, miss_tag_s;
  logic                   hit_s, inv_found_s;
  logic [WAY_BITS-1:0]    hit_way_s, inv_way_s, lru_way_s, victim_s, touch_way_s;
  logic [LINE_W-1:0]      hit_line_s;
  logic [31:0]            hit_word_s, fill_word_s;
  logic                   flush_go_s, accept_s, acc_hit_s, acc_miss_s;
  logic                   fill_s, flush_last_s, touch_s;
  logic                   unused_s;

  assign req_off_s  = proc_addr[OFFSET_BITS+1:2];
  assign req_idx_s  = proc_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_tag_s  = proc_addr[31 -: TAG_BITS];
  // The pending line address doubles as the source of the fill index and tag.
  assign miss_idx_s = mem_req_addr_q[OFFSET_BITS+2 +: INDEX_BITS];
  assign miss_tag_s = mem_req_addr_q[31 -: TAG_BITS];
  assign unused_s   = &{1'b0, proc_addr[1:0]};

  assign hit_line_s  = data_q[hit_way_s][req_idx_s];
  assign hit_word_s  = hit_line_s[{req_off_s, 5'd0} +: 32];
  assign fill_word_s = mem_req_rdata[{miss_off_q, 5'd0} +: 32];

  // A pending flush is served before any new request.
  assign flush_go_s   = (state_q == S_IDLE) && (flush || flush_pend_q);
  assign accept_s     = (state_q == S_IDLE) && !flush_go_s && proc_valid;
  assign acc_hit_s    = accept_s && hit_s;
  assign acc_miss_s   = accept_s && !hit_s;
  assign fill_s       = (state_q == S_MISS) && mem_req_ready;
  assign flush_last_s = (state_q == S_FLUSH) && (flush_idx_q == LAST_SET);

  assign touch_s     = acc_hit_s || fill_s;
  assign touch_way_s = fill_s ? victim_q : hit_way_s;
  assign touch_idx_s = fill_s ? miss_idx_s : req_idx_s;

  // Tag compare of the requested set across all ways.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WAY_BITS{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][req_idx_s] && (tag_q[w][req_idx_s] == req_tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_BITS'(w);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Victim choice: lowest invalid way, else policy way (RR pointer or oldest age).
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = {WAY_BITS{1'b0}};
    lru_way_s   = {WAY_BITS{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx_s]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_BITS'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_q[w][req_idx_s] == LAST_WAY) begin
        lru_way_s = WAY_BITS'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    if (inv_found_s) begin
      victim_s = inv_way_s;
    end else if (REPL_POLICY == 1) begin
      victim_s = lru_way_s;
    end else begin
      victim_s = rr_q[req_idx_s];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush_go_s)      state_d = S_FLUSH;
        else if (acc_hit_s)  state_d = S_RESP;
        else if (acc_miss_s) state_d = S_MISS;
        else                 state_d = S_IDLE;
      end
      S_MISS:  state_d = fill_s ? S_RESP : S_MISS;
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: state_d = flush_last_s ? S_IDLE : S_FLUSH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output strobes follow the state being entered so they are registered.
  always_comb begin
    proc_ready_d    = (state_d == S_RESP);
    mem_req_valid_d = (state_d == S_MISS);
    flush_busy_d    = (state_d == S_FLUSH);
  end

  // Datapath next-state values.
  always_comb begin
    mem_req_addr_d = mem_req_addr_q;
    miss_off_d     = miss_off_q;
    victim_d       = victim_q;
    if (acc_miss_s) begin
      mem_req_addr_d = {proc_addr[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
      miss_off_d     = req_off_s;
      victim_d       = victim_s;
    end else begin
      mem_req_addr_d = mem_req_addr_q;
    end
    if (acc_hit_s)   proc_rdata_d = hit_word_s;
    else if (fill_s) proc_rdata_d = fill_word_s;
    else             proc_rdata_d = proc_rdata_q;
    if (flush_go_s)                        flush_pend_d = 1'b0;
    else if (flush && state_q != S_IDLE)   flush_pend_d = 1'b1;
    else                                   flush_pend_d = flush_pend_q;
    flush_idx_d  = (state_q == S_FLUSH) ? flush_idx_q + 1'b1 : {INDEX_BITS{1'b0}};
    hit_count_d  = acc_hit_s  ? hit_count_q + 32'd1  : hit_count_q;
    miss_count_d = acc_miss_s ? miss_count_q + 32'd1 : miss_count_q;
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      proc_ready_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      flush_busy_q    <= 1'b0;
      mem_req_addr_q  <= 32'd0;
      proc_rdata_q    <= 32'd0;
      miss_off_q      <= {OFFSET_BITS{1'b0}};
      victim_q        <= {WAY_BITS{1'b0}};
      flush_idx_q     <= {INDEX_BITS{1'b0}};
      flush_pend_q    <= 1'b0;
      hit_count_q     <= 32'd0;
      miss_count_q    <= 32'd0;
    end else begin
      proc_ready_q    <= proc_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      flush_busy_q    <= flush_busy_d;
      mem_req_addr_q  <= mem_req_addr_d;
      proc_rdata_q    <= proc_rdata_d;
      miss_off_q      <= miss_off_d;
      victim_q        <= victim_d;
      flush_idx_q     <= flush_idx_d;
      flush_pend_q    <= flush_pend_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  // Line fill of tag and data into the chosen victim way.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[victim_q][miss_idx_s]  <= miss_tag_s;
      data_q[victim_q][miss_idx_s] <= mem_req_rdata;
    end
  end

  // Valid bits and replacement state: reset, per-set flush, fill and touch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= {WAY_BITS{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) age_q[w][s] <= WAY_BITS'(w);
      end
    end else begin
      if (state_q == S_FLUSH) begin
        rr_q[flush_idx_q] <= {WAY_BITS{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[w][flush_idx_q] <= 1'b0;
          age_q[w][flush_idx_q]   <= WAY_BITS'(w);
        end
      end
      if (fill_s) begin
        valid_q[victim_q][miss_idx_s] <= 1'b1;
        rr_q[miss_idx_s]              <= rr_q[miss_idx_s] + ONE_WAY;
      end
      // Younger ways than the touched one age by one; the touched way becomes 0.
      if (touch_s) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == touch_way_s)
            age_q[w][touch_idx_s] <= {WAY_BITS{1'b0}};
          else if (age_q[w][touch_idx_s] < age_q[touch_way_s][touch_idx_s])
            age_q[w][touch_idx_s] <= age_q[w][touch_idx_s] + ONE_WAY;
        end
      end
    end
  end

  assign proc_ready    = proc_ready_q;
  assign proc_rdata    = proc_rdata_q;
  assign flush_busy    = flush_busy_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_icache_nway_wide.sv
// Bench for icache_nway_wide: one round-robin and one LRU instance share the
// clock and reset. A behavioural model keeps, per set, the cached line numbers,
// a round-robin pointer and a most-recently-used ordering list, and predicts
// hit/miss, data and counters for directed and random fetch sequences.
module tb_icache_nway_wide;
  localparam int NW = 2;
  localparam int NS = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            pv    [2];
  logic [31:0]     pa    [2];
  logic            fl    [2];
  logic            mrr   [2];
  logic [NB*32-1:0] mrd  [2];
  logic            prdy  [2];
  logic [31:0]     prd   [2];
  logic            fbusy [2];
  logic            mval  [2];
  logic [31:0]     maddr [2];
  logic [31:0]     hc    [2];
  logic [31:0]     mc    [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      icache_nway_wide #(
        .CACHE_SIZE(1024), .NUM_WAYS(NW), .NUM_BLOCKS(NB), .REPL_POLICY(g)
      ) u_dut (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[g]), .proc_ready(prdy[g]), .proc_addr(pa[g]), .proc_rdata(prd[g]),
        .flush(fl[g]), .flush_busy(fbusy[g]),
        .mem_req_valid(mval[g]), .mem_req_ready(mrr[g]), .mem_req_addr(maddr[g]),
        .mem_req_rdata(mrd[g]),
        .hit_count(hc[g]), .miss_count(mc[g])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  bit          m_valid [2][NS][NW];
  int unsigned m_line  [2][NS][NW];
  int          m_rr    [2][NS];
  int          m_ord   [2][NS][NW];   // m_ord[..][0] = most recently used way
  int unsigned m_hits  [2];
  int unsigned m_miss  [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 4) == 32'h10) return 32'hA + ((a >> 2) & 32'h3);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [NB*32-1:0] line_data(input logic [31:0] a);
    logic [NB*32-1:0] ld;
    for (int k = 0; k < NB; k++) ld[32*k +: 32] = mem_word((a & 32'hFFFFFFF0) + 32'(4 * k));
    return ld;
  endfunction

  function automatic void model_reset(input int d, input bit counters);
    for (int s = 0; s < NS; s++) begin
      m_rr[d][s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[d][s][w] = 1'b0;
        m_ord[d][s][w]   = w;
      end
    end
    if (counters) begin
      m_hits[d] = 0;
      m_miss[d] = 0;
    end
  endfunction

  function automatic void model_touch(input int d, input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (m_ord[d][s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_ord[d][s][i] = m_ord[d][s][i-1];
    m_ord[d][s][0] = w;
  endfunction

  function automatic void model_access(input int d, input logic [31:0] addr, output bit hit);
    int unsigned line = addr >> 4;
    int s = int'(line % NS);
    int v = -1;
    hit = 1'b0;
    for (int w = 0; w < NW; w++)
      if (m_valid[d][s][w] && m_line[d][s][w] == line) begin
        hit = 1'b1; v = w;
      end
    if (hit) begin
      m_hits[d]++;
      model_touch(d, s, v);
      return;
    end
    m_miss[d]++;
    for (int w = NW - 1; w >= 0; w--) if (!m_valid[d][s][w]) v = w;
    if (v < 0) v = (d == 1) ? m_ord[d][s][NW-1] : m_rr[d][s];
    m_valid[d][s][v] = 1'b1;
    m_line[d][s][v]  = line;
    m_rr[d][s]       = (m_rr[d][s] + 1) % NW;
    model_touch(d, s, v);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One fetch on instance d; mem answers after lat wait cycles.
  task automatic do_read(input int d, input logic [31:0] addr, input int lat, input bit prompt,
                         input bit flush_mid, input bit hold, input bit reset_mid,
                         output bit obs_hit);
    bit exp_hit;
    bit got;
    int n;
    model_access(d, addr, exp_hit);
    obs_hit = 1'b0;
    @(negedge clk);
    pv[d] = 1'b1;
    pa[d] = addr;
    got = 1'b0;
    n = 0;
    while (!got && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (prdy[d] || mval[d]) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      pv[d] = 1'b0;
      return;
    end
    if (prompt) chk("accept_latency", n, 32'd1);
    obs_hit = prdy[d] && !mval[d];
    chk("hit_or_miss", obs_hit, exp_hit);
    if (mval[d]) begin
      chk("mem_req_addr", maddr[d], addr & 32'hFFFFFFF0);
      chk("miss_no_ready", prdy[d], 32'd0);
      if (reset_mid) begin
        @(negedge clk);
        resetn = 1'b0;
        pv[d]  = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem_valid", mval[d], 32'd0);
        chk("rst_ready", prdy[d], 32'd0);
        chk("rst_hit_count", hc[d], 32'd0);
        chk("rst_miss_count", mc[d], 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset(0, 1'b1);
        model_reset(1, 1'b1);
        return;
      end
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (flush_mid && i == 0) fl[d] = 1'b1;
        @(posedge clk); #1;
        fl[d] = 1'b0;
        chk("miss_wait_valid", mval[d], 32'd1);
        chk("miss_wait_ready", prdy[d], 32'd0);
      end
      @(negedge clk);
      mrr[d] = 1'b1;
      mrd[d] = line_data(addr);
      @(posedge clk); #1;
      mrr[d] = 1'b0;
      mrd[d] = {$urandom, $urandom, $urandom, $urandom};
      chk("fill_ready", prdy[d], 32'd1);
      chk("fill_valid_low", mval[d], 32'd0);
    end
    chk("rdata", prd[d], mem_word(addr & 32'hFFFFFFFC));
    chk("hit_count", hc[d], m_hits[d]);
    chk("miss_count", mc[d], m_miss[d]);
    if (hold) begin
      @(posedge clk); #1;
      chk("hold_no_ready", prdy[d], 32'd0);
      chk("hold_no_req", mval[d], 32'd0);
      chk("hold_hit_count", hc[d], m_hits[d]);
      chk("hold_miss_count", mc[d], m_miss[d]);
    end
    @(negedge clk);
    pv[d] = 1'b0;
  endtask

  // Waits (bounded) for flush_busy, then measures its length.
  task automatic wait_flush(input int d);
    int n = 0;
    int cnt = 0;
    bit resp = 1'b0;
    while (!fbusy[d] && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    while (fbusy[d] && cnt < 100) begin
      cnt++;
      if (prdy[d] || mval[d]) resp = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_busy_cycles", cnt, 32'd32);
    chk("flush_no_response", resp, 32'd0);
    model_reset(d, 1'b0);
  endtask

  task automatic pulse_flush(input int d, input bit hold_req, input logic [31:0] addr);
    @(negedge clk);
    fl[d] = 1'b1;
    if (hold_req) begin
      pv[d] = 1'b1;
      pa[d] = addr;
    end
    @(posedge clk); #1;
    fl[d] = 1'b0;
    chk("flush_start", fbusy[d], 32'd1);
    wait_flush(d);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [31:0] a;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; pa[d] = 32'd0; fl[d] = 1'b0; mrr[d] = 1'b0; mrd[d] = '0;
      model_reset(d, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", prdy[d], 32'd0);
      chk("reset_mem_valid", mval[d], 32'd0);
      chk("reset_mem_addr", maddr[d], 32'd0);
      chk("reset_rdata", prd[d], 32'd0);
      chk("reset_flush_busy", fbusy[d], 32'd0);
      chk("reset_hit_count", hc[d], 32'd0);
      chk("reset_miss_count", mc[d], 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Cold miss then hit on the round-robin instance.
    do_read(0, 32'h100, 1, 1'b1, 1'b0, 1'b0, 1'b0, h);
    chk("cold_miss", h, 32'd0);
    chk("cold_word0", prd[0], 32'hA);
    do_read(0, 32'h108, 0, 1'b1, 1'b0, 1'b0, 1'b0, h);
    chk("warm_hit", h, 32'd1);
    chk("warm_word2", prd[0], 32'hC);
    chk("warm_hits", hc[0], 32'd1);
    chk("warm_misses", mc[0], 32'd1);

    // Round-robin conflict in set 0.
    do_read(0, 32'h000, 2, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("rr_fill0", h, 32'd0);
    do_read(0, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("rr_fill1", h, 32'd0);
    do_read(0, 32'h400, 1, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("rr_conflict", h, 32'd0);
    do_read(0, 32'h204, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("rr_keep_200", h, 32'd1);
    do_read(0, 32'h00C, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("rr_evicted_000", h, 32'd0);

    // LRU conflict in set 0.
    do_read(1, 32'h000, 1, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_fill0", h, 32'd0);
    do_read(1, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_fill1", h, 32'd0);
    do_read(1, 32'h004, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_touch0", h, 32'd1);
    do_read(1, 32'h400, 2, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_conflict", h, 32'd0);
    do_read(1, 32'h008, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_keep_000", h, 32'd1);
    do_read(1, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("lru_evicted_200", h, 32'd0);

    // Flush from idle with a request held; the request then misses.
    pulse_flush(0, 1'b1, 32'h000);
    do_read(0, 32'h000, 1, 1'b0, 1'b0, 1'b0, 1'b0, h);
    chk("post_flush_miss", h, 32'd0);

    // Flush arriving during a refill waits for the response.
    do_read(1, 32'h300, 3, 1'b1, 1'b1, 1'b0, 1'b0, h);
    chk("flush_mid_fill_miss", h, 32'd0);
    wait_flush(1);
    do_read(1, 32'h300, 0, 1'b1, 1'b0, 1'b0, 1'b0, h);
    chk("flush_mid_refetch_miss", h, 32'd0);

    // Reset mid-miss drops the request and clears all state.
    do_read(0, 32'h500, 0, 1'b1, 1'b0, 1'b0, 1'b0, h);
    do_read(0, 32'h504, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("pre_reset_hit", h, 32'd1);
    do_read(0, 32'h7C0, 2, 1'b1, 1'b0, 1'b0, 1'b1, h);
    do_read(0, 32'h500, 1, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("post_reset_miss", h, 32'd0);
    do_read(1, 32'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0, h); chk("post_reset_miss_lru", h, 32'd0);

    // Back-to-back: proc_valid held through the response cycle.
    do_read(0, 32'h508, 0, 1'b1, 1'b0, 1'b1, 1'b0, h); chk("hold_hit", h, 32'd1);
    do_read(0, 32'h50C, 1, 1'b1, 1'b0, 1'b1, 1'b0, h); chk("hold_hit2", h, 32'd1);

    // Random traffic over a few conflicting sets, with occasional flushes.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          pulse_flush(d, 1'b0, 32'd0);
        end else begin
          a = 32'($urandom_range(0, 3) * 512 + $urandom_range(0, 2) * 16 +
                  $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
          do_read(d, a, int'($urandom_range(0, 3)), 1'b1, 1'b0,
                  bit'($urandom_range(0, 1)), 1'b0, h);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_nway_wide.md
# icache_nway_wide

Parametrised N-way set-associative instruction cache with a full-line refill port, selectable replacement policy (round-robin or true LRU), a multi-cycle flush and hit/miss counters. It sits between the core's instruction fetch port and the wide instruction memory. It returns a hit in one cycle and forwards the critical word directly from refill data on a miss.

## Interface
- CACHE_SIZE, 1024: capacity in bytes; power of two.
- NUM_WAYS, 2: associativity; power of two, ≥2.
- NUM_BLOCKS, 4: 32-bit words per line; power of two, ≥2.
- REPL_POLICY, 0: 0 = per-set round-robin, 1 = per-set LRU (age counters).
- Derived values:
  - NUM_SETS = CACHE_SIZE/(4·NUM_BLOCKS·NUM_WAYS), ≥2.
  - OFFSET_BITS = clog2(NUM_BLOCKS); INDEX_BITS = clog2(NUM_SETS).
  - TAG_BITS = 30−OFFSET_BITS−INDEX_BITS.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- proc_valid  in  1  fetch request; held with proc_addr until proc_ready.
- proc_ready  out  1  one-cycle response strobe.
- proc_addr  in  32  byte address; bits [1:0] ignored.
- proc_rdata  out  32  instruction word; valid while proc_ready=1.
- flush  in  1  one-cycle invalidate-all request.
- flush_busy  out  1  high while invalidation is in progress.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  one-cycle strobe; mem_req_rdata valid in the same cycle.
- mem_req_addr  out  32  line-aligned address.
- mem_req_rdata  in  32·NUM_BLOCKS  line data; word k = bits [32k+31:32k].
- hit_count  out  32  accepted hits, wraps mod 2^32.
- miss_count  out  32  accepted misses, wraps mod 2^32.

## Operation
- Address split: offset = addr[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = addr[31:32−TAG_BITS].
- States and transitions:
  - IDLE:
    - flush or a pending flush → FLUSH. Flush has priority over proc_valid.
    - Otherwise proc_valid → combinational tag compare across all ways.
    - On a hit: latch the word into proc_rdata, update replacement state, hit_count+1, → RESP.
    - On a miss: latch address, mem_req_addr = {addr[31:OFFSET_BITS+2], 0}, choose the victim way, miss_count+1, → MISS.
  - MISS:
    - mem_req_valid=1, with mem_req_addr stable.
    - On mem_req_ready: write line, tag and valid to the victim way; update replacement state; proc_rdata = word[offset] of mem_req_rdata; → RESP.
  - RESP: proc_ready=1 for exactly one cycle; proc_valid is ignored; → IDLE.
  - FLUSH:
    - Clears valid for all ways of one set per cycle, set 0 to NUM_SETS−1.
    - Resets replacement state for that set.
    - flush_busy=1 throughout; → IDLE after the last set.
- A flush asserted outside IDLE sets a pending bit. The pending flush runs on the next IDLE cycle, before any new request is accepted.
- Victim selection:
  - The lowest-index invalid way, if any.
  - Otherwise, round-robin: the set pointer; the pointer increments (mod NUM_WAYS) on fill only.
  - Otherwise, LRU: the way whose age = NUM_WAYS−1.
- LRU update on a hit or fill to way w: every way with age < age[w] increments, then age[w]=0.
- LRU initial/flush state: age[w]=w.
- Counters are cleared only by reset, not by flush.

## Timing
- Reset values:
  - proc_ready=0, mem_req_valid=0, mem_req_addr=0, proc_rdata=0, flush_busy=0.
  - Counters 0; all valid bits 0; RR pointers 0; LRU ages = way index; pending flush cleared; state IDLE.
- Reset in any state (including MISS or FLUSH) takes effect at the next edge. An abandoned memory request is simply dropped.
- Hit: request sampled at edge N → proc_ready high in cycle N+1.
- Miss: request sampled at edge N → mem_req_valid high from cycle N+1. mem_req_ready sampled at edge M → mem_req_valid low and proc_ready high in cycle M+1.
- Minimum gap between accepted requests is 2 cycles, because RESP blocks re-acceptance of a still-asserted proc_valid.
- Flush from IDLE: flush sampled at edge N → flush_busy high for exactly NUM_SETS cycles starting N+1. The first request accepted is at the edge ending the last flush cycle or later.
- hit_count/miss_count update at the acceptance edge (visible in N+1).

## Test plan
- Cold miss then hit:
  - Stimulus (defaults): read 0x100 → mem_req_addr=0x100; return words {0xD,0xC,0xB,0xA} (word0=0xA).
  - Required: proc_rdata=0xA one cycle after mem_req_ready.
  - Then read 0x108 → proc_ready at N+1, data 0xC, no mem_req_valid; hit_count=1, miss_count=1.
- Round-robin conflict (REPL_POLICY=0):
  - Stimulus: fill set 0 with 0x000 and 0x200, then read 0x400.
  - Required: 0x400 evicts 0x000; re-reading 0x000 misses; 0x200 hits.
- LRU (REPL_POLICY=1):
  - Stimulus: 0x000, 0x200, hit 0x000, then read 0x400.
  - Required: 0x400 evicts 0x200; 0x000 hits; 0x200 misses.
- Flush from IDLE:
  - Stimulus: after the fills above, pulse flush while holding proc_valid on 0x000.
  - Required: flush_busy high exactly 32 cycles with no response; then 0x000 misses (miss_count+1).
- Flush during MISS:
  - Stimulus: assert flush while mem_req_valid=1.
  - Required: the refill completes and proc_ready pulses; then flush_busy runs 32 cycles; the just-filled line then misses.
- Reset mid-miss and back-to-back:
  - Stimulus: resetn low while mem_req_valid=1.
  - Required: next cycle mem_req_valid=0, counters=0, previously cached lines miss.
  - Stimulus: hold proc_valid high through the proc_ready cycle.
  - Required: no duplicate acceptance or counter increment.
